// File: rtl/tanh_result_collector.sv
// Result collector for the bf16->fp32 tanh LUT core: tracks samples through the
// core's enable-gated pipeline, buffers results in a FIFO and issues credits upstream.
module tanh_result_collector #(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 8,
    parameter int AW      = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tanh_enable,
    input  logic          issue_valid,
    output logic          issue_ready,
    input  logic [31:0]   tanh_result,
    output logic          out_valid,
    output logic [31:0]   out_data,
    input  logic          out_ready,
    output logic [AW:0]   fill_level,
    output logic          overflow_err
);

    localparam int IW = $clog2(LATENCY + 1);
    localparam int SW = ((AW + 1) > IW ? (AW + 1) : IW) + 1;

    logic [LATENCY-1:0] vpipe;
    logic [IW-1:0]      inflight;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;
    logic [31:0]        mem [DEPTH];

    logic               accept;
    logic               push;
    logic               pop;
    logic               reject;
    logic [SW-1:0]      occupancy;

    // Credits cover both buffered and in-flight results, so push never meets a full FIFO.
    assign occupancy   = SW'(count) + SW'(inflight);
    assign issue_ready = occupancy < SW'(DEPTH);

    assign accept = issue_valid & tanh_enable & issue_ready;
    assign reject = issue_valid & tanh_enable & ~issue_ready;
    assign push   = vpipe[LATENCY-1] & tanh_enable;
    assign pop    = out_valid & out_ready;

    assign out_valid  = (count != '0);
    assign out_data   = mem[rd_ptr];
    assign fill_level = count;

    // Valid tags mirror the core's pipeline and stall with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vpipe <= '0;
        end else if (tanh_enable) begin
            vpipe <= {vpipe[LATENCY-2:0], accept};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            unique case ({accept, push})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is left unreset; out_valid masks stale contents.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= tanh_result;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_err <= 1'b0;
        end else if (reject) begin
            overflow_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tanh_result_collector.sv
// Bench for tanh_result_collector: stub tanh core, queue-based reference model,
// per-cycle compare process and directed scenarios with literal expectations.
module tb_tanh_result_collector;

    localparam int LAT = 4;
    localparam int DEP = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tanh_enable = 1'b1;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic [31:0] tanh_result;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready = 1'b0;
    logic [3:0]  fill_level;
    logic        overflow_err;
    logic [31:0] sample_val = '0;

    int tests = 0;
    int fails = 0;

    tanh_result_collector #(.LATENCY(LAT), .DEPTH(DEP), .AW(3)) dut (
        .clk(clk), .rst(rst), .tanh_enable(tanh_enable),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .tanh_result(tanh_result), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready),
        .fill_level(fill_level), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    // Stub core: enable-gated delay line, never reset.
    logic [31:0] cp [LAT];
    always @(posedge clk) begin
        if (tanh_enable) begin
            cp[0] <= issue_valid ? sample_val : 32'hDEADBEEF;
            for (int i = 1; i < LAT; i++) cp[i] <= cp[i-1];
        end
    end
    assign tanh_result = cp[LAT-1];

    // Reference model: accepted samples wait LAT enabled edges, then join a queue.
    typedef struct {
        logic [31:0] v;
        int          k;
    } item_t;
    item_t       inq[$];
    logic [31:0] mq[$];
    bit          m_ovf = 0;

    function automatic bit m_ready();
        return (mq.size() + inq.size()) < DEP;
    endfunction

    bit    rdy_m;
    item_t it;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            inq.delete();
            m_ovf = 0;
        end else begin
            rdy_m = m_ready();
            if (mq.size() != 0 && out_ready) void'(mq.pop_front());
            if (tanh_enable) begin
                foreach (inq[i]) inq[i].k--;
                while (inq.size() > 0 && inq[0].k == 0) begin
                    it = inq.pop_front();
                    mq.push_back(it.v);
                end
                if (issue_valid) begin
                    if (rdy_m) inq.push_back('{sample_val, LAT});
                    else m_ovf = 1;
                end
            end
        end
    end

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) chk("out_data", out_data, mq[0]);
        chk("fill_level", 32'(fill_level), 32'(mq.size()));
        chk("issue_ready", 32'(issue_ready), 32'(m_ready()));
        chk("overflow_err", 32'(overflow_err), 32'(m_ovf));
    end

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_ovf_clear", 32'(overflow_err), 32'd0);
        chk("rst_fill", 32'(fill_level), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int idx;
    int cyc;

    initial begin
        step(2);
        chk("reset_ready", 32'(issue_ready), 32'd1);
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_fill", 32'(fill_level), 32'd0);
        chk("reset_ovf", 32'(overflow_err), 32'd0);
        rst = 1'b0;
        step();

        // 1: single sample, push on the 4th edge after the accepting edge
        issue_valid = 1'b1;
        sample_val = 32'h3F42F7C5;
        step();
        issue_valid = 1'b0;
        step(3);
        chk("t1_not_yet", 32'(out_valid), 32'd0);
        step();
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_data", out_data, 32'h3F42F7C5);
        chk("t1_fill", 32'(fill_level), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t1_drained", 32'(fill_level), 32'd0);

        // 2: eight back-to-back samples, no draining
        for (int i = 0; i < 8; i++) begin
            issue_valid = 1'b1;
            sample_val = 32'h40000000 + 32'(i);
            step();
        end
        issue_valid = 1'b0;
        chk("t2_ready_low", 32'(issue_ready), 32'd0);
        step(3);
        chk("t2_fill7", 32'(fill_level), 32'd7);
        step();
        chk("t2_fill8", 32'(fill_level), 32'd8);
        chk("t2_no_ovf", 32'(overflow_err), 32'd0);

        // 3: one issue while no credit
        issue_valid = 1'b1;
        sample_val = 32'hBADBAD00;
        step();
        issue_valid = 1'b0;
        chk("t3_ovf", 32'(overflow_err), 32'd1);
        step(6);
        chk("t3_ovf_sticky", 32'(overflow_err), 32'd1);
        chk("t3_fill8", 32'(fill_level), 32'd8);
        chk("t3_head", out_data, 32'h40000000);
        out_ready = 1'b1;
        step(8);
        out_ready = 1'b0;
        chk("t3_drained", 32'(fill_level), 32'd0);

        // 4: enable toggling while streaming five samples
        pulse_rst();
        idx = 0;
        cyc = 0;
        while (cyc < 40) begin
            tanh_enable = pat[cyc % 4];
            issue_valid = (idx < 5);
            sample_val = 32'h3F000000 + 32'(idx);
            step();
            if (tanh_enable && issue_valid) idx++;
            cyc++;
        end
        issue_valid = 1'b0;
        tanh_enable = 1'b1;
        step();
        chk("t4_fill5", 32'(fill_level), 32'd5);
        chk("t4_no_ovf", 32'(overflow_err), 32'd0);
        for (int k = 0; k < 5; k++) begin
            chk("t4_order", out_data, 32'h3F000000 + 32'(k));
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
        chk("t4_empty", 32'(out_valid), 32'd0);

        // 5: full FIFO then continuous drain with new issues
        pulse_rst();
        for (int i = 0; i < 8; i++) begin
            issue_valid = 1'b1;
            sample_val = 32'h41000000 + 32'(i);
            step();
        end
        issue_valid = 1'b0;
        step(5);
        chk("t5_full", 32'(fill_level), 32'd8);
        out_ready = 1'b1;
        idx = 8;
        for (int c = 0; c < 30; c++) begin
            issue_valid = m_ready();
            sample_val = 32'h41000000 + 32'(idx);
            step();
            if (issue_valid) idx++;
        end
        issue_valid = 1'b0;
        step(12);
        out_ready = 1'b0;
        chk("t5_empty", 32'(fill_level), 32'd0);
        chk("t5_no_ovf", 32'(overflow_err), 32'd0);

        // 6: reset with three in flight and two buffered
        pulse_rst();
        for (int i = 0; i < 5; i++) begin
            issue_valid = 1'b1;
            sample_val = 32'h42000000 + 32'(i);
            step();
        end
        issue_valid = 1'b0;
        step();
        chk("t6_fill2", 32'(fill_level), 32'd2);
        chk("t6_ready", 32'(issue_ready), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_fill", 32'(fill_level), 32'd0);
        chk("t6_rst_ready", 32'(issue_ready), 32'd1);
        step();
        rst = 1'b0;
        step(10);
        chk("t6_no_stale", 32'(out_valid), 32'd0);
        chk("t6_fill0", 32'(fill_level), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
